// File: rtl/dmem_pkg.sv
// Shared types and sizing helpers for the data-memory responder.
// Optional bounds checking is enabled with DMEM_BOUNDS_CHECK_EN.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int CNT_W = 4;
  localparam int LANES = 4;

  function automatic int idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with byte-enable writes and a registered read port.
// The read register returns the merged word on a store.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int DATA_W = 32,
  localparam int IDX_W = idx_w(MEM_WORDS),
  localparam int NB = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [NB-1:0]     i_be,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [MEM_WORDS];
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] w_merged;

  always_comb begin
    w_merged = r_mem[i_idx];
    for (int i = 0; i < NB; i++) begin
      if (i_be[i]) w_merged[8*i +: 8] = i_wdata[8*i +: 8];
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (i_en && i_we) r_mem[i_idx] <= w_merged;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_en) begin
      r_rdata <= i_we ? w_merged : r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage load/store target: one request at a time, LATENCY wait states.
// Define DMEM_BOUNDS_CHECK_EN to flag out-of-range word addresses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int MEM_WORDS = 256,
  parameter int LATENCY = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                busy
);

  localparam int IDX_W = idx_w(MEM_WORDS);
  localparam int WRD_W = ADDR_W - 2;
  localparam int NB = DATA_W / 8;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [WRD_W-1:0]  r_word;
  logic [DATA_W-1:0] r_wdata;
  logic [NB-1:0]     r_be;
  logic              r_req_ready;
  logic              r_resp_valid;
  logic              r_err;
  logic              r_busy;

  logic              w_idle;
  logic              w_accept;
  logic              w_enter;
  logic              w_we;
  logic [WRD_W-1:0]  w_word;
  logic [DATA_W-1:0] w_wdata;
  logic [NB-1:0]     w_be;
  logic              w_oob;
  logic              w_en;
  logic [DATA_W-1:0] w_rdata;
  logic              w_unused;

  assign w_idle   = (r_state == IDLE);
  assign w_accept = req_valid & r_req_ready;

  // With zero latency the array acts on the acceptance edge itself.
  assign w_we    = w_idle ? req_we : r_we;
  assign w_word  = w_idle ? req_addr[ADDR_W-1:2] : r_word;
  assign w_wdata = w_idle ? req_wdata : r_wdata;
  assign w_be    = w_idle ? req_be : r_be;

  assign w_enter = w_idle
    ? (w_accept && (LATENCY == 0))
    : ((r_state == WAIT) && (r_cnt == '0));

`ifdef DMEM_BOUNDS_CHECK_EN
  assign w_oob = ({1'b0, w_word} >= (WRD_W + 1)'(MEM_WORDS));
`else
  assign w_oob = 1'b0;
`endif

  assign w_en     = w_enter & ~w_oob & reset;
  assign w_unused = ^{req_addr[1:0], w_word};

  dmem_array #(
    .MEM_WORDS(MEM_WORDS),
    .DATA_W   (DATA_W)
  ) u_array (
    .clk    (clk),
    .rst_n  (reset),
    .i_en   (w_en),
    .i_we   (w_we),
    .i_idx  (w_word[IDX_W-1:0]),
    .i_wdata(w_wdata),
    .i_be   (w_be),
    .o_rdata(w_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_word       <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we        <= req_we;
            r_word      <= req_addr[ADDR_W-1:2];
            r_wdata     <= req_wdata;
            r_be        <= req_be;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (LATENCY == 0) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_err        <= w_oob;
            end else begin
              r_state <= WAIT;
              r_cnt   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_err        <= w_oob;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_busy       <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_err ? '0 : w_rdata;
  assign resp_err   = r_err;
  assign busy       = r_busy;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: a LATENCY=2/ADDR_W=12 responder and a LATENCY=0 one.
// Bounds expectations follow DMEM_BOUNDS_CHECK_EN.
module tb_dmem_responder;

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam logic BCHK = 1'b1;
`else
  localparam logic BCHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        t_valid;
  logic        t_we;
  logic [11:0] t_addr;
  logic [31:0] t_wdata;
  logic [3:0]  t_be;
  logic        t_rready;

  logic        v1, rr1, rv1, er1, bz1;
  logic [31:0] rd1;
  logic        v0, rr0, rv0, er0, bz0;
  logic [31:0] rd0;

  logic        m_rr, m_rv, m_er, m_bz;
  logic [31:0] m_rd;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign v1   = t_valid & ~sel;
  assign v0   = t_valid & sel;
  assign m_rr = sel ? rr0 : rr1;
  assign m_rv = sel ? rv0 : rv1;
  assign m_rd = sel ? rd0 : rd1;
  assign m_er = sel ? er0 : er1;
  assign m_bz = sel ? bz0 : bz1;

  dmem_responder #(
    .ADDR_W(12), .DATA_W(32), .MEM_WORDS(256), .LATENCY(2)
  ) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(v1), .req_ready(rr1), .req_we(t_we),
    .req_addr(t_addr), .req_wdata(t_wdata), .req_be(t_be),
    .resp_valid(rv1), .resp_ready(t_rready),
    .resp_rdata(rd1), .resp_err(er1), .busy(bz1)
  );

  dmem_responder #(
    .ADDR_W(10), .DATA_W(32), .MEM_WORDS(256), .LATENCY(0)
  ) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(v0), .req_ready(rr0), .req_we(t_we),
    .req_addr(t_addr[9:0]), .req_wdata(t_wdata), .req_be(t_be),
    .resp_valid(rv0), .resp_ready(t_rready),
    .resp_rdata(rd0), .resp_err(er0), .busy(bz0)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic txn(input logic we, input logic [11:0] a,
                     input logic [31:0] wd, input logic [3:0] be,
                     output logic [31:0] rd, output logic er,
                     output int lat);
    int n;
    @(negedge clk);
    t_we = we; t_addr = a; t_wdata = wd; t_be = be;
    t_rready = 1'b1; t_valid = 1'b1;
    n = 0;
    while (!m_rr && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    t_valid = 1'b0;
    lat = 1;
    while (!m_rv && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = m_rd;
    er = m_er;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;

    vecs[0]  = '{1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 1'b0};
    vecs[1]  = '{1'b0, 12'h010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 12'h010, 32'h000000AA, 4'h1, 32'hDEADBEAA, 1'b0};
    vecs[3]  = '{1'b0, 12'h010, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0};
    vecs[4]  = '{1'b1, 12'h013, 32'h11223344, 4'hC, 32'h1122BEAA, 1'b0};
    vecs[5]  = '{1'b0, 12'h011, 32'h0, 4'h0, 32'h1122BEAA, 1'b0};
    vecs[6]  = '{1'b1, 12'h010, 32'hFFFFFFFF, 4'h0, 32'h1122BEAA, 1'b0};
    vecs[7]  = '{1'b1, 12'h020, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D, 1'b0};
    vecs[8]  = '{1'b1, 12'h3FC, 32'hA5A5A5A5, 4'hF, 32'hA5A5A5A5, 1'b0};
    vecs[9]  = '{1'b1, 12'h000, 32'h01020304, 4'hF, 32'h01020304, 1'b0};
    vecs[10] = '{1'b0, 12'h3FC, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0};
    vecs[11] = '{1'b1, 12'h400, 32'h55667788, 4'hF,
                 BCHK ? 32'h0 : 32'h55667788, BCHK};
    vecs[12] = '{1'b0, 12'h000, 32'h0, 4'h0,
                 BCHK ? 32'h01020304 : 32'h55667788, 1'b0};

    reset = 1'b0; sel = 1'b0; t_valid = 1'b0; t_we = 1'b0;
    t_addr = '0; t_wdata = '0; t_be = '0; t_rready = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_req_ready", 32'(rr1), 32'd1);
    chk("rst_resp_valid", 32'(rv1), 32'd0);
    chk("rst_rdata", rd1, 32'h0);
    chk("rst_err", 32'(er1), 32'd0);
    chk("rst_busy", 32'(bz1), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
          rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd3);
    end

    // Backpressure: response held, competing store must not be taken.
    @(negedge clk);
    t_we = 1'b0; t_addr = 12'h020; t_rready = 1'b0; t_valid = 1'b1;
    @(posedge clk); #1;
    t_valid = 1'b0;
    n = 0;
    while (!rv1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_first_rdata", rd1, 32'hCAFEF00D);
    @(negedge clk);
    t_we = 1'b1; t_wdata = 32'h0; t_be = 4'hF; t_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_valid", i), 32'(rv1), 32'd1);
      chk($sformatf("bp%0d_rdata", i), rd1, 32'hCAFEF00D);
      chk($sformatf("bp%0d_req_ready", i), 32'(rr1), 32'd0);
      chk($sformatf("bp%0d_busy", i), 32'(bz1), 32'd1);
    end
    t_valid = 1'b0; t_rready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(rv1), 32'd0);
    chk("bp_release_ready", 32'(rr1), 32'd1);
    txn(1'b0, 12'h020, 32'h0, 4'h0, rd, er, lat);
    chk("bp_after_load", rd, 32'hCAFEF00D);

    // Reset during WAIT of a store.
    @(negedge clk);
    t_we = 1'b1; t_addr = 12'h020; t_wdata = 32'hBAD0BAD0;
    t_be = 4'hF; t_rready = 1'b1; t_valid = 1'b1;
    @(posedge clk); #1;
    t_valid = 1'b0;
    chk("mid_busy", 32'(bz1), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_req_ready", 32'(rr1), 32'd1);
    chk("mid_rst_valid", 32'(rv1), 32'd0);
    chk("mid_rst_rdata", rd1, 32'h0);
    chk("mid_rst_busy", 32'(bz1), 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    txn(1'b0, 12'h020, 32'h0, 4'h0, rd, er, lat);
    chk("mid_rst_load", rd, 32'hCAFEF00D);

    // Zero-latency instance.
    sel = 1'b1;
    txn(1'b1, 12'h004, 32'h11111111, 4'hF, rd, er, lat);
    chk("l0_st1_rdata", rd, 32'h11111111);
    chk("l0_st1_lat", 32'(lat), 32'd1);
    txn(1'b1, 12'h008, 32'h22222222, 4'hF, rd, er, lat);
    chk("l0_st2_lat", 32'(lat), 32'd1);
    @(negedge clk);
    t_we = 1'b0; t_addr = 12'h004; t_rready = 1'b1; t_valid = 1'b1;
    chk("b2b_n0_ready", 32'(rr0), 32'd1);
    @(negedge clk);
    chk("b2b_n1_valid", 32'(rv0), 32'd1);
    chk("b2b_n1_rdata", rd0, 32'h11111111);
    chk("b2b_n1_ready", 32'(rr0), 32'd0);
    t_addr = 12'h008;
    @(negedge clk);
    chk("b2b_n2_valid", 32'(rv0), 32'd0);
    chk("b2b_n2_ready", 32'(rr0), 32'd1);
    @(negedge clk);
    chk("b2b_n3_valid", 32'(rv0), 32'd1);
    chk("b2b_n3_rdata", rd0, 32'h22222222);
    t_valid = 1'b0;
    @(negedge clk);
    chk("b2b_n4_valid", 32'(rv0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the target end of the CPU pipeline's MEM-stage load/store interface.
- Accepts one read or write request at a time over a valid/ready handshake, inserts a programmable number of wait states, then returns a response over a second valid/ready handshake.
- Holds the word-organised storage array. Replaces ad-hoc memory models behind the CPU top level, and serves as a standalone target for the CPU bench.

Parameters:
- ADDR_W, 10, byte-address width of req_addr.
- DATA_W, 32, data width. Fixed at 32; byte lanes = DATA_W/8 = 4.
- MEM_WORDS, 256, storage depth in words. Must be a power of two, ≤ 2^(ADDR_W-2).
- LATENCY, 2, wait states between acceptance and response. Range 0..15.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  ADDR_W  byte address; bits [1:0] ignored
- req_wdata  input  DATA_W  store data
- req_be  input  DATA_W/8  store byte enables; bit i gates bits [8i+7:8i]
- resp_valid  output  1  response present
- resp_ready  input  1  requester accepts response
- resp_rdata  output  DATA_W  load data, or merged word after a store
- resp_err  output  1  out-of-range access (see Optional Feature)
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset low, asynchronous): state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, busy = 0, wait counter = 0. Memory contents are not affected by reset.
- FSM states: IDLE, WAIT, RESP. req_ready = (state == IDLE), registered.
- IDLE: request accepted on an edge where req_valid & req_ready. That edge latches we/addr/wdata/be.
  - LATENCY > 0: go to WAIT, counter = LATENCY-1.
  - LATENCY == 0: go straight to RESP.
- WAIT: counter decrements each cycle. On the edge where counter == 0, go to RESP.
- Memory action happens on the edge entering RESP (same edge that raises resp_valid):
  - store: write byte lanes with be = 1; lanes with be = 0 are unchanged. resp_rdata = merged word.
  - load: resp_rdata = mem[index].
- Word index = req_addr[ADDR_W-1:2] truncated to log2(MEM_WORDS) bits.
- Timing: resp_valid rises exactly LATENCY+1 cycles after the acceptance edge.
- RESP: resp_valid = 1. resp_rdata and resp_err stay stable until resp_ready is high at an edge. On that handshake, go to IDLE and drop resp_valid.
- resp_ready held low: stay in RESP indefinitely, no new request accepted.
- Throughput: at most one request per LATENCY+2 cycles. No acceptance is possible in the same cycle as a response handshake.
- req_be == 0 on a store: no lanes written; response returns the unchanged word.
- req_valid may drop before acceptance without error. Inputs other than those of the accepted request are ignored.
- Reset mid-operation: transaction aborted, no response. A store whose write edge has not yet occurred leaves memory unchanged.

Optional Feature:
- Macro DMEM_BOUNDS_CHECK_EN.
- Defined: accesses with req_addr[ADDR_W-1:2] ≥ MEM_WORDS get resp_err = 1 and resp_rdata = 0, with no memory write. Latency is unchanged.
- Undefined: resp_err is tied 0 and the index wraps modulo MEM_WORDS.

Decomposition:
- Package dmem_pkg: state enum (IDLE, WAIT, RESP), lane-count and index-width localparams, LATENCY counter width (4 bits).
- One sub-module, dmem_array: synchronous write with byte enables and synchronous read, parameterised by MEM_WORDS and DATA_W. The FSM, counter and handshakes stay in dmem_responder.

Test Plan:
- Reset, then LATENCY=2, store addr 0x010, wdata 0xDEADBEEF, be 4'hF → resp_valid 3 cycles after acceptance, resp_rdata 0xDEADBEEF. Then load 0x010 → 0xDEADBEEF after 3 cycles.
- Partial store 0x010, wdata 0x000000AA, be 4'b0001 → response and subsequent load return 0xDEADBEAA.
- Backpressure: resp_ready held low 5 cycles → resp_valid and resp_rdata stable, req_ready = 0, busy = 1. A concurrent req_valid is not accepted.
- LATENCY=0 build: back-to-back loads with resp_ready = 1 → each response 1 cycle after acceptance, one transaction per 2 cycles.
- reset asserted during WAIT of a store to 0x020 → outputs at reset values immediately; later load 0x020 returns the prior contents.
- With DMEM_BOUNDS_CHECK_EN, MEM_WORDS=256, ADDR_W=12: store 0x400 → resp_err = 1, rdata 0. Load 0x000 unchanged. Without the macro, same store writes word 0.
